clock_divider_monitor: RTL and testbench

- Receive-side checker for a divided clock such as the FIFO sys_clk.
- Samples the divided clock in the fast clk domain and measures the number of clk cycles between successive toggles, which is the divide ratio that produced it.
- Declares lock after LOCK_COUNT consecutive identical measurements. Flags slips and timeouts.
- Lets the FIFO/control logic confirm that sys_clk runs at the programmed ratio before enabling traffic.

---
 rtl/clock_divider_monitor.sv | 159 +++++++++++++++
 tb/tb_clock_divider_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_monitor.sv
// clock_divider_monitor
//   Receive-side checker for a divided clock (e.g. the FIFO sys_clk). The
//   divided clock is sampled in the fast clk domain. The monitor counts clk
//   cycles between successive toggles, rising or falling, which gives the
//   divide ratio. It declares lock after LOCK_COUNT consecutive identical
//   intervals, and flags slips and timeouts.
//
// Ports
//   clk          in   fast reference clock (also drives the divider)
//   reset        in   synchronous, active-high reset
//   div_clk_in   in   divided clock under test, synchronous to clk
//   expected_div in   [8:0] programmed divide ratio
//   clr_err      in   one-cycle pulse, clears the sticky error flags
//   meas_div     out  [8:0] last measured interval in clk cycles
//   meas_valid   out  one-cycle pulse when meas_div updates
//   locked       out  LOCK_COUNT consecutive equal intervals seen
//   div_match    out  locked and meas_div == expected_div
//   slip_err     out  sticky: interval changed while locked
//   timeout_err  out  sticky: no toggle for TIMEOUT cycles while measuring
module clock_divider_monitor #(
    parameter int LOCK_COUNT = 4,    // 2..15
    parameter int TIMEOUT    = 511   // max 511
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       div_clk_in,
    input  logic [8:0] expected_div,
    input  logic       clr_err,
    output logic [8:0] meas_div,
    output logic       meas_valid,
    output logic       locked,
    output logic       div_match,
    output logic       slip_err,
    output logic       timeout_err
);

    localparam logic [3:0] LC = LOCK_COUNT[3:0];
    localparam logic [8:0] TO = TIMEOUT[8:0];

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t     state_q, state_d;
    logic       prev_q;
    logic [8:0] cnt_q, cnt_d;
    logic [3:0] run_q, run_d;
    logic [8:0] meas_div_q, meas_div_d;
    logic       meas_valid_q, meas_valid_d;
    logic       locked_q, locked_d;
    logic       div_match_q, div_match_d;
    logic       slip_q, slip_d;
    logic       tout_q, tout_d;

    logic       tog;
    logic       same;
    logic       slip_set;
    logic       tout_set;

    // prev resets to 1, the divider's reset level of its output.
    assign tog  = div_clk_in ^ prev_q;
    assign same = (cnt_q == meas_div_q);

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        meas_div_d   = meas_div_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        slip_set     = 1'b0;
        tout_set     = 1'b0;

        // cnt equals the toggle period in the cycle where the next toggle is seen.
        if (tog) begin
            cnt_d = 9'd1;
        end else if (cnt_q >= TO) begin
            cnt_d = TO;
        end else begin
            cnt_d = cnt_q + 9'd1;
        end

        case (state_q)
            SEARCH: begin
                // The first interval is partial, so only arm the measurement.
                if (tog) begin
                    state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (tog) begin
                    meas_div_d   = cnt_q;
                    meas_valid_d = 1'b1;
                    if (state_q == LOCKED && !same) begin
                        slip_set = 1'b1;
                        locked_d = 1'b0;
                        run_d    = 4'd1;
                        state_d  = MEASURE;
                    end else begin
                        // run == 0 means meas_div is stale (reset or timeout).
                        if (same && run_q != 4'd0) begin
                            run_d = (run_q >= LC) ? LC : run_q + 4'd1;
                        end else begin
                            run_d = 4'd1;
                        end
                        locked_d = (run_d == LC);
                        state_d  = locked_d ? LOCKED : MEASURE;
                    end
                end else if (cnt_q == TO) begin
                    tout_set = 1'b1;
                    locked_d = 1'b0;
                    run_d    = 4'd0;
                    state_d  = SEARCH;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        // A set event wins over a coincident clear.
        slip_d = slip_set | (slip_q & ~clr_err);
        tout_d = tout_set | (tout_q & ~clr_err);

        // Use next-state values so div_match changes in the same cycle as locked.
        div_match_d = locked_d && (meas_div_d == expected_div);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEARCH;
            prev_q       <= 1'b1;
            cnt_q        <= 9'd0;
            run_q        <= 4'd0;
            meas_div_q   <= 9'd0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            div_match_q  <= 1'b0;
            slip_q       <= 1'b0;
            tout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= div_clk_in;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            meas_div_q   <= meas_div_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            div_match_q  <= div_match_d;
            slip_q       <= slip_d;
            tout_q       <= tout_d;
        end
    end

    assign meas_div    = meas_div_q;
    assign meas_valid  = meas_valid_q;
    assign locked      = locked_q;
    assign div_match   = div_match_q;
    assign slip_err    = slip_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_clock_divider_monitor.sv
module tb_clock_divider_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       div_clk_in;
    logic [8:0] expected_div;
    logic       clr_err;
    logic [8:0] meas_div;
    logic       meas_valid;
    logic       locked;
    logic       div_match;
    logic       slip_err;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    // Packed status: {meas_valid, locked, div_match, slip_err, timeout_err}
    logic [4:0] st;
    assign st = {meas_valid, locked, div_match, slip_err, timeout_err};

    clock_divider_monitor #(.LOCK_COUNT(4), .TIMEOUT(511)) dut (
        .clk          (clk),
        .reset        (reset),
        .div_clk_in   (div_clk_in),
        .expected_div (expected_div),
        .clr_err      (clr_err),
        .meas_div     (meas_div),
        .meas_valid   (meas_valid),
        .locked       (locked),
        .div_match    (div_match),
        .slip_err     (slip_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // One sampled clk cycle; optionally toggle the divided clock first.
    task automatic step(input bit t);
        if (t) div_clk_in = ~div_clk_in;
        @(posedge clk);
        #1;
    endtask

    // One interval of d cycles ending with a toggle in the last cycle.
    task automatic iv(input int d);
        repeat (d - 1) step(1'b0);
        step(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; div_clk_in = 1'b1; expected_div = 9'd5; clr_err = 1'b0;
        step(1'b0);
        step(1'b0);
        tests++; if (st !== 5'b00000) begin fails++; $display("FAIL reset_status got=%b exp=%b", st, 5'b00000); end
        tests++; if (meas_div !== 9'd0) begin fails++; $display("FAIL reset_meas got=%0d exp=0", meas_div); end
        reset = 1'b0;
    endtask

    task automatic test_ratio5();
        logic [4:0] e;
        step(1'b1);
        tests++; if (st !== 5'b00000) begin fails++; $display("FAIL r5_first_edge got=%b exp=00000", st); end
        for (int i = 0; i < 4; i++) begin
            iv(5);
            e = {1'b1, i == 3, i == 3, 2'b00};
            tests++; if (meas_div !== 9'd5) begin fails++; $display("FAIL r5_meas[%0d] got=%0d exp=5", i, meas_div); end
            tests++; if (st !== e) begin fails++; $display("FAIL r5_status[%0d] got=%b exp=%b", i, st, e); end
        end
        expected_div = 9'd6;
        step(1'b0);
        tests++; if (st !== 5'b01000) begin fails++; $display("FAIL r5_exp6 got=%b exp=01000", st); end
        expected_div = 9'd5;
        step(1'b0);
        tests++; if (st !== 5'b01100) begin fails++; $display("FAIL r5_exp5 got=%b exp=01100", st); end
        iv(3);
        tests++; if (st !== 5'b11100 || meas_div !== 9'd5) begin fails++; $display("FAIL r5_steady got=%b/%0d exp=11100/5", st, meas_div); end
    endtask

    task automatic test_slip();
        logic [4:0] e;
        iv(8);
        tests++; if (meas_div !== 9'd8) begin fails++; $display("FAIL slip_meas got=%0d exp=8", meas_div); end
        tests++; if (st !== 5'b10010) begin fails++; $display("FAIL slip_status got=%b exp=10010", st); end
        for (int i = 0; i < 3; i++) begin
            iv(8);
            e = {1'b1, i == 2, 1'b0, 1'b1, 1'b0};
            tests++; if (st !== e) begin fails++; $display("FAIL relock8[%0d] got=%b exp=%b", i, st, e); end
        end
        clr_err = 1'b1;
        step(1'b0);
        clr_err = 1'b0;
        tests++; if (st !== 5'b01000) begin fails++; $display("FAIL slip_clear got=%b exp=01000", st); end
        iv(7);
        tests++; if (st !== 5'b11000 || meas_div !== 9'd8) begin fails++; $display("FAIL locked8 got=%b/%0d exp=11000/8", st, meas_div); end
    endtask

    task automatic test_clr_vs_slip();
        repeat (4) step(1'b0);
        clr_err = 1'b1;
        step(1'b1);
        clr_err = 1'b0;
        tests++; if (st !== 5'b10010 || meas_div !== 9'd5) begin fails++; $display("FAIL clr_vs_slip got=%b/%0d exp=10010/5", st, meas_div); end
    endtask

    task automatic test_timeout();
        clr_err = 1'b1;
        step(1'b0);
        clr_err = 1'b0;
        tests++; if (st !== 5'b00000) begin fails++; $display("FAIL to_pre_clear got=%b exp=00000", st); end
        iv(4);
        iv(5);
        tests++; if (st !== 5'b10000) begin fails++; $display("FAIL to_run3 got=%b exp=10000", st); end
        iv(5);
        tests++; if (st !== 5'b11100) begin fails++; $display("FAIL to_locked got=%b exp=11100", st); end
        repeat (510) step(1'b0);
        tests++; if (st !== 5'b01100) begin fails++; $display("FAIL to_510 got=%b exp=01100", st); end
        step(1'b0);
        tests++; if (st !== 5'b00001) begin fails++; $display("FAIL to_511 got=%b exp=00001", st); end
        tests++; if (meas_div !== 9'd5) begin fails++; $display("FAIL to_meas_hold got=%0d exp=5", meas_div); end
        repeat (20) step(1'b0);
        step(1'b1);
        tests++; if (st !== 5'b00001) begin fails++; $display("FAIL to_search_edge got=%b exp=00001", st); end
        iv(5);
        tests++; if (st !== 5'b10001 || meas_div !== 9'd5) begin fails++; $display("FAIL to_remeasure got=%b/%0d exp=10001/5", st, meas_div); end
        clr_err = 1'b1;
        step(1'b0);
        clr_err = 1'b0;
        repeat (509) step(1'b0);
        step(1'b1);
        tests++; if (st !== 5'b10000 || meas_div !== 9'd511) begin fails++; $display("FAIL to_iv511 got=%b/%0d exp=10000/511", st, meas_div); end
    endtask

    task automatic test_ratio1();
        logic [4:0] e;
        reset = 1'b1; div_clk_in = 1'b1;
        step(1'b0);
        reset = 1'b0;
        tests++; if (st !== 5'b00000 || meas_div !== 9'd0) begin fails++; $display("FAIL r1_reset got=%b/%0d exp=00000/0", st, meas_div); end
        expected_div = 9'd1;
        step(1'b1);
        tests++; if (st !== 5'b00000) begin fails++; $display("FAIL r1_first got=%b exp=00000", st); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            e = {1'b1, i == 3, i == 3, 2'b00};
            tests++; if (st !== e || meas_div !== 9'd1) begin fails++; $display("FAIL r1[%0d] got=%b/%0d exp=%b/1", i, st, meas_div, e); end
        end
    endtask

    task automatic test_reset_locked();
        reset = 1'b1; div_clk_in = 1'b1;
        step(1'b0);
        reset = 1'b0;
        expected_div = 9'd3;
        step(1'b1);
        repeat (4) iv(3);
        tests++; if (st !== 5'b11100 || meas_div !== 9'd3) begin fails++; $display("FAIL r3_locked got=%b/%0d exp=11100/3", st, meas_div); end
        reset = 1'b1; div_clk_in = 1'b1;
        step(1'b0);
        reset = 1'b0;
        tests++; if (st !== 5'b00000 || meas_div !== 9'd0) begin fails++; $display("FAIL r3_reset got=%b/%0d exp=00000/0", st, meas_div); end
        step(1'b0);
        step(1'b1);
        tests++; if (st !== 5'b00000) begin fails++; $display("FAIL r3_first_edge got=%b exp=00000", st); end
        iv(3);
        tests++; if (st !== 5'b10000 || meas_div !== 9'd3) begin fails++; $display("FAIL r3_second_edge got=%b/%0d exp=10000/3", st, meas_div); end
    endtask

    initial begin
        test_reset();
        test_ratio5();
        test_slip();
        test_clr_vs_slip();
        test_timeout();
        test_ratio1();
        test_reset_locked();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
